mem_burst_reader: RTL and testbench

//   Sequential read front-end for the Memory block (7-bit address, 64-bit combinational read).

---
 rtl/mem_burst_reader.sv | 121 ++++++++++++
 tb/tb_mem_burst_reader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_reader.sv
// Burst read front-end: walks consecutive memory addresses and streams each word
// out through a small FIFO on a valid/ready interface. Backpressure stalls addressing.
//
// state | meaning
// IDLE  | waiting for a request; req_ready high
// BURST | issuing addresses and pushing words while the FIFO has room
// DRAIN | all words pushed; waiting for the last-flagged word to be popped
module mem_burst_reader #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 64,
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    output logic [ADDR_W-1:0] mem_adr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = FIFO_DEPTH[PTR_W:0];

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_t;

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  rem;
    logic [PTR_W:0]    count;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic              fifo_last [FIFO_DEPTH];
    logic [DATA_W-1:0] hold_data;
    logic              done_nxt;
    logic              accept, push, pop, head_last;

    assign accept    = req_valid && (state == S_IDLE);
    assign push      = (state == S_BURST) && (count < FULL_CNT);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign head_last = fifo_last[rd_ptr];

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    // When empty the last popped word stays visible on out_data.
    assign out_data  = out_valid ? fifo_data[rd_ptr] : hold_data;
    assign out_last  = out_valid && head_last;

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_len != '0) state_nxt = S_BURST;
                    else               done_nxt  = 1'b1;
                end
            end
            S_BURST: begin
                if (push && rem == LEN_W'(1)) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (pop && head_last) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            done      <= 1'b0;
            mem_adr   <= '0;
            rem       <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            hold_data <= '0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            if (accept && req_len != '0) begin
                mem_adr <= req_addr;
                rem     <= req_len;
            end else if (push) begin
                mem_adr <= mem_adr + ADDR_W'(1);
                rem     <= rem - LEN_W'(1);
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                hold_data <= fifo_data[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= mem_data;
            fifo_last[wr_ptr] <= (rem == LEN_W'(1));
        end
    end

endmodule

// File: tb/tb_mem_burst_reader.sv
// Self-checking bench for mem_burst_reader: behavioural memory mem[i]=i*3 and a
// queue-based model of the expected word stream per burst.
module tb_mem_burst_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_addr;
    logic [7:0]  req_len;
    logic [6:0]  mem_adr;
    logic [63:0] mem_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;
    logic [64:0] exp_q[$];

    always #5 clk = ~clk;

    assign mem_data = 64'(mem_adr) * 64'd3;

    mem_burst_reader dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len),
        .mem_adr(mem_adr), .mem_data(mem_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    task automatic push_exp(input int addr, input int len);
        for (int i = 0; i < len; i++) begin
            int a;
            a = (addr + i) % 128;
            exp_q.push_back({(i == len - 1) ? 1'b1 : 1'b0, 64'(a * 3)});
        end
    endtask

    task automatic start_req(input int addr, input int len);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL req_ready_idle: got %b want 1", req_ready);
        end
        push_exp(addr, len);
        req_addr  = 7'(addr);
        req_len   = 8'(len);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic collect(input int pct);
        int  cyc;
        bit  started;
        logic [64:0] e;
        cyc = 0;
        started = 0;
        while (exp_q.size() != 0 && cyc < 5000) begin
            out_ready = ($urandom_range(99) < pct);
            n_cmp++;
            if (done !== 1'b0) begin
                n_err++;
                $display("FAIL early_done: got %b want 0", done);
            end
            if (out_valid === 1'b1) started = 1;
            else if (pct >= 100 && started) begin
                n_cmp++;
                n_err++;
                $display("FAIL throughput_gap: out_valid %b want 1", out_valid);
            end
            if (out_valid === 1'b1 && out_ready) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (out_data !== e[63:0] || out_last !== e[64]) begin
                    n_err++;
                    $display("FAIL beat: got data %0d last %b want data %0d last %b",
                             out_data, out_last, e[63:0], e[64]);
                end
            end
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL timeout: %0d words outstanding want 0", exp_q.size());
            exp_q.delete();
            return;
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL done_pulse: got done %b busy %b valid %b want 1 0 0",
                     done, busy, out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL done_width: got %b want 0", done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; out_ready = 1'b0;
        #12;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mem_adr !== 7'd0 ||
            out_data !== 64'd0 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: valid %b busy %b done %b adr %0d data %0d last %b want all 0",
                     out_valid, busy, done, mem_adr, out_data, out_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        start_req(20, 1);
        collect(100);
    endtask

    task automatic test_burst4();
        out_ready = 1'b1;
        start_req(5, 4);
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL latency_accept: valid %b busy %b want 0 1", out_valid, busy);
        end
        collect(100);
    endtask

    task automatic test_wrap();
        start_req(126, 4);
        collect(100);
        n_cmp++;
        if (mem_adr !== 7'd2) begin
            n_err++;
            $display("FAIL wrap_adr: got %0d want 2", mem_adr);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        start_req(45, 8);
        repeat (10) @(negedge clk);
        n_cmp++;
        if (mem_adr !== 7'd49 || out_valid !== 1'b1 || out_data !== 64'd135 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL stall: adr %0d valid %b data %0d busy %b want 49 1 135 1",
                     mem_adr, out_valid, out_data, busy);
        end
        collect(100);
    endtask

    task automatic test_zero_len();
        out_ready = 1'b1;
        start_req(7, 0);
        n_cmp++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL zero_len: done %b valid %b busy %b want 1 0 0", done, out_valid, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL zero_len_after: done %b valid %b want 0 0", done, out_valid);
        end
    endtask

    task automatic test_busy_reject();
        out_ready = 1'b0;
        start_req(10, 3);
        for (int i = 0; i < 5; i++) begin
            req_addr = 7'd99; req_len = 8'd2; req_valid = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (req_ready !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL busy_reject: ready %b busy %b want 0 1", req_ready, busy);
            end
        end
        req_valid = 1'b0;
        n_cmp++;
        if (mem_adr !== 7'd13) begin
            n_err++;
            $display("FAIL busy_adr: got %0d want 13", mem_adr);
        end
        collect(100);
        n_cmp++;
        if (mem_adr !== 7'd13) begin
            n_err++;
            $display("FAIL idle_adr_hold: got %0d want 13", mem_adr);
        end
    endtask

    task automatic test_reset_mid();
        int beats;
        int cyc;
        logic [64:0] e;
        out_ready = 1'b1;
        start_req(111, 10);
        beats = 0;
        cyc = 0;
        while (beats < 3 && cyc < 50) begin
            if (out_valid === 1'b1) begin
                e = exp_q.pop_front();
                beats++;
                n_cmp++;
                if (out_data !== e[63:0] || out_last !== e[64]) begin
                    n_err++;
                    $display("FAIL mid_beat: got data %0d last %b want data %0d last %b",
                             out_data, out_last, e[63:0], e[64]);
                end
            end
            @(negedge clk);
            cyc++;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mem_adr !== 7'd0 ||
            out_data !== 64'd0 || out_last !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: valid %b busy %b done %b adr %0d data %0d last %b want all 0",
                     out_valid, busy, done, mem_adr, out_data, out_last);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_req(54, 2);
        collect(100);
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            start_req($urandom_range(127), $urandom_range(1, 40));
            collect($urandom_range(20, 100));
        end
        start_req(0, 128);
        collect(100);
        start_req($urandom_range(127), 128);
        collect(60);
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst4();
        test_wrap();
        test_stall();
        test_zero_len();
        test_busy_reject();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
